// File: rtl/mul_pkg.sv
// mul_pkg: constants shared by the serial multiplier and its dot-product
// sequencer.
//   OP_W    operand lane width
//   PROD_W  product width of one lane multiply
//   ST_*    dot_prod_ctrl state encoding (2-bit, kept as plain constants so
//           legacy code comparing against raw codes still lines up)
package mul_pkg;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   // Index width for selecting one of n lanes; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult.sv
// mult: serial shift-add unsigned multiplier, one operand bit per cycle.
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       accepted only while idle; latches a_bi/b_bi
//   a_bi, b_bi    OP_W-bit unsigned operands
//   busy_o        high for exactly OP_W cycles after an accepted start
//   y_bo          PROD_W-bit product, valid and held once busy_o is low
module mult
   import mul_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [OP_W-1:0]   a_bi,
   input  logic [OP_W-1:0]   b_bi,
   output logic              busy_o,
   output logic [PROD_W-1:0] y_bo
);

   localparam int unsigned CNT_W = $clog2(OP_W);

   logic              busy;
   logic [PROD_W-1:0] a_sh;
   logic [OP_W-1:0]   b_sh;
   logic [CNT_W-1:0]  cnt;
   logic [PROD_W-1:0] acc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy <= 1'b0;
         a_sh <= '0;
         b_sh <= '0;
         cnt  <= '0;
         acc  <= '0;
      end else if (!busy) begin
         if (start_i) begin
            busy <= 1'b1;
            a_sh <= PROD_W'(a_bi);
            b_sh <= b_bi;
            cnt  <= '0;
            acc  <= '0;
         end
      end else begin
         if (b_sh[0]) begin
            acc <= acc + a_sh;
         end
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(OP_W - 1)) begin
            busy <= 1'b0;
         end
      end
   end

   assign busy_o = busy;
   assign y_bo   = acc;

endmodule

// File: rtl/dot_prod_ctrl.sv
// dot_prod_ctrl: sequences N lane multiplies through an external mult block
// and accumulates y = sum(a[i]*b[i]) over 8-bit unsigned lanes.
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               request, only honoured in IDLE
//   a_bi, b_bi            packed lanes, lane i at bits [8i+7:8i]
//   busy_o                high whenever not IDLE
//   y_bo                  ACC_W-bit result, held until the next completion
//   mul_start_o           one-cycle start pulse to mult
//   mul_a_bo, mul_b_bo    current lane operands to mult
//   mul_busy_i, mul_y_bi  busy and product from mult
module dot_prod_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned N     = 3,
   parameter int unsigned ACC_W = PROD_W + $clog2(N)
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [OP_W*N-1:0] a_bi,
   input  logic [OP_W*N-1:0] b_bi,
   output logic              busy_o,
   output logic [ACC_W-1:0]  y_bo,
   output logic              mul_start_o,
   output logic [OP_W-1:0]   mul_a_bo,
   output logic [OP_W-1:0]   mul_b_bo,
   input  logic              mul_busy_i,
   input  logic [PROD_W-1:0] mul_y_bi
);

   localparam int unsigned IDX_W = idx_width(N);

   logic [1:0]          state;
   logic [IDX_W-1:0]    idx;
   logic [OP_W*N-1:0]   a_lat;
   logic [OP_W*N-1:0]   b_lat;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    y_reg;
   logic [ACC_W-1:0]    prod_ext;
   logic                last_term;

   always_comb begin
      prod_ext  = ACC_W'(mul_y_bi);
      last_term = (idx == IDX_W'(N - 1));
   end

   // WAIT_HI exists because mult only raises busy the cycle after it sees
   // start; without it the controller would mistake the pre-start idle for
   // completion and consume a stale product.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         idx   <= '0;
         a_lat <= '0;
         b_lat <= '0;
         acc   <= '0;
         y_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  a_lat <= a_bi;
                  b_lat <= b_bi;
                  idx   <= '0;
                  acc   <= '0;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (mul_busy_i) begin
                  state <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               if (!mul_busy_i) begin
                  if (last_term) begin
                     y_reg <= acc + prod_ext;
                     state <= ST_IDLE;
                  end else begin
                     acc   <= acc + prod_ext;
                     idx   <= idx + IDX_W'(1);
                     state <= ST_ISSUE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Lane select from the latched copy so operands stay put for the whole
   // term regardless of what the parent does to a_bi/b_bi.
   always_comb begin
      mul_a_bo = '0;
      mul_b_bo = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == IDX_W'(i)) begin
            mul_a_bo = a_lat[i*OP_W +: OP_W];
            mul_b_bo = b_lat[i*OP_W +: OP_W];
         end
      end
   end

   assign busy_o      = (state != ST_IDLE);
   assign mul_start_o = (state == ST_ISSUE);
   assign y_bo        = y_reg;

endmodule

// File: tb/tb_dot_prod_ctrl.sv
module tb_dot_prod_ctrl;
   import mul_pkg::*;

   localparam int unsigned N     = 3;
   localparam int unsigned ACC_W = 18;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [31:0] y;
      int unsigned len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [23:0] a_in = '0;
   logic [23:0] b_in = '0;
   logic        busy;
   logic [ACC_W-1:0] y;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic        mul_busy;
   logic [15:0] mul_y;

   logic        rm_busy;
   logic [15:0] rm_y;
   logic        bm_busy;
   logic [15:0] bm_y;
   logic [15:0] bm_prod;
   int unsigned bm_cnt;
   int unsigned m_lat = 8;
   logic        use_real = 1'b0;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic in_rst = 1'b1;

   always #5 clk = ~clk;

   dot_prod_ctrl #(.N(N), .ACC_W(ACC_W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .a_bi(a_in), .b_bi(b_in),
      .busy_o(busy), .y_bo(y), .mul_start_o(mul_start), .mul_a_bo(mul_a),
      .mul_b_bo(mul_b), .mul_busy_i(mul_busy), .mul_y_bi(mul_y)
   );

   mult real_mul (
      .clk_i(clk), .rst_i(rst), .start_i(mul_start), .a_bi(mul_a),
      .b_bi(mul_b), .busy_o(rm_busy), .y_bo(rm_y)
   );

   // Behavioural multiplier: busy for m_lat cycles, junk on y until done.
   always @(posedge clk) begin
      if (rst) begin
         bm_busy <= 1'b0;
         bm_y    <= '0;
         bm_prod <= '0;
         bm_cnt  <= 0;
      end else if (bm_busy) begin
         if (bm_cnt == 0) begin
            bm_busy <= 1'b0;
            bm_y    <= bm_prod;
         end else begin
            bm_cnt <= bm_cnt - 1;
         end
      end else if (mul_start) begin
         bm_busy <= 1'b1;
         bm_cnt  <= m_lat - 1;
         bm_prod <= 16'(mul_a) * 16'(mul_b);
         bm_y    <= 16'hBEEF;
      end
   end

   assign mul_busy = use_real ? rm_busy : bm_busy;
   assign mul_y    = use_real ? rm_y    : bm_y;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dot3(input logic [23:0] a, input logic [23:0] b);
      logic [31:0] s = 0;
      for (int i = 0; i < 3; i++) s += 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
      return s;
   endfunction

   // Output monitor: scoreboard pops on every busy fall.
   int unsigned busy_cnt = 0;
   int unsigned pulses = 0;
   int unsigned run = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t cur;
      if (in_rst) begin
         busy_cnt = 0; pulses = 0; run = 0; prev_busy = 1'b0;
      end else begin
         if (mul_start) begin
            if (run == 0) begin
               if (sb.size() == 0) begin
                  check("sb_empty_on_start", 1, 0);
               end else begin
                  cur = sb[0];
                  check("lane_a", 32'(mul_a), 32'(cur.a[pulses*8 +: 8]));
                  check("lane_b", 32'(mul_b), 32'(cur.b[pulses*8 +: 8]));
               end
               pulses++;
            end
            run++;
         end else if (run != 0) begin
            check("start_width", run, 1);
            run = 0;
         end
         if (busy) busy_cnt++;
         if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
               check("sb_empty_on_done", 1, 0);
            end else begin
               cur = sb.pop_front();
               check("result", 32'(y), cur.y);
               check("busy_len", busy_cnt, cur.len);
               check("start_pulses", pulses, N);
            end
            busy_cnt = 0;
            pulses = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic wait_busy(input logic level, input int budget);
      int n = 0;
      while (busy !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== level) check("timeout", 32'(busy), 32'(level));
   endtask

   task automatic push_exp(input logic [23:0] a, input logic [23:0] b, input int unsigned m);
      exp_t e;
      e.a = a; e.b = b; e.y = dot3(a, b); e.len = N * (m + 2);
      sb.push_back(e);
   endtask

   task automatic run_op(input logic [23:0] a, input logic [23:0] b, input int unsigned m);
      @(negedge clk);
      a_in = a; b_in = b; start = 1'b1;
      push_exp(a, b, m);
      @(negedge clk);
      start = 1'b0;
      check("accept", 32'(busy), 1);
      wait_busy(1'b0, 400);
      @(negedge clk);
   endtask

   task automatic hit_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1; in_rst = 1'b1; sb.delete();
      repeat (cycles) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_y", 32'(y), 0);
      check("rst_mul_start", 32'(mul_start), 0);
      rst = 1'b0;
      @(negedge clk);
      in_rst = 1'b0;
   endtask

   initial begin
      hit_reset(2);
      check("rst_mul_a", 32'(mul_a), 0);
      check("rst_mul_b", 32'(mul_b), 0);

      // basic and maximum
      run_op(24'h030201, 24'h060504, 8);
      run_op(24'hFFFFFF, 24'hFFFFFF, 8);
      check("max_direct", 32'(y), 32'h2FA03);

      // inputs poked mid-operation are ignored
      @(negedge clk);
      a_in = 24'h030201; b_in = 24'h060504; start = 1'b1;
      push_exp(24'h030201, 24'h060504, 8);
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      start = 1'b1; a_in = '0; b_in = '0;
      @(negedge clk);
      start = 1'b0;
      wait_busy(1'b0, 400);
      repeat (3) @(negedge clk);
      check("no_extra_op", 32'(busy), 0);
      check("sb_drained", sb.size(), 0);

      // reset during WAIT_LO of term 1, then a fresh operation
      @(negedge clk);
      a_in = 24'h030201; b_in = 24'h060504; start = 1'b1;
      push_exp(24'h030201, 24'h060504, 8);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      hit_reset(1);
      run_op(24'h010101, 24'h020202, 8);

      // back-to-back with start held, M=1 then M=20
      @(negedge clk);
      m_lat = 1;
      a_in = 24'h0A0B0C; b_in = 24'h010203; start = 1'b1;
      push_exp(24'h0A0B0C, 24'h010203, 1);
      @(negedge clk);
      check("b2b_accept1", 32'(busy), 1);
      wait_busy(1'b0, 400);
      m_lat = 20;
      a_in = 24'hFF0180; b_in = 24'h02FF03;
      push_exp(24'hFF0180, 24'h02FF03, 20);
      @(negedge clk);
      check("b2b_gap", 32'(busy), 1);
      start = 1'b0;
      wait_busy(1'b0, 400);
      @(negedge clk);

      // against the real mult
      m_lat = 8;
      use_real = 1'b1;
      run_op(24'h030201, 24'h060504, 8);
      run_op(24'hFFFFFF, 24'hFFFFFF, 8);
      run_op(24'h7F80C3, 24'h11FE5A, 8);
      check("sb_final", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
